// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch and the MEM stage.
// Data side wins contested cycles until STARVE_MAX in a row, then fetch is forced through once.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    typedef enum logic [0:0] {
        PRI_D = 1'b0,
        PRI_F = 1'b1
    } pri_e;

    pri_e             r_state;
    pri_e             w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_contest;
    logic             w_if_gnt;
    logic             w_d_gnt;
    logic             r_rd_pend;
    logic             r_rd_owner;

    assign w_contest = i_if_req & i_d_req;

    // Arbitration state and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PRI_D;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: only contested cycles advance the counter; any fetch grant restores data priority.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {CNT_W{1'b0}};
        if (w_contest) begin
            case (r_state)
                PRI_D: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = PRI_F;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = PRI_D;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                PRI_F: begin
                    w_state_nxt = PRI_D;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
                default: begin
                    w_state_nxt = PRI_D;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            endcase
        end else if (i_if_req) begin
            w_state_nxt = PRI_D;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            w_state_nxt = r_state;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end
    end

    // Grants and RAM access; everything is held quiet while reset is asserted.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (rst) begin
            w_if_gnt = 1'b0;
            w_d_gnt  = 1'b0;
        end else if (w_contest) begin
            w_if_gnt = (r_state == PRI_F);
            w_d_gnt  = (r_state != PRI_F);
        end else begin
            w_if_gnt = i_if_req;
            w_d_gnt  = i_d_req;
        end
        o_if_gnt    = w_if_gnt;
        o_d_gnt     = w_d_gnt;
        o_mem_en    = w_if_gnt | w_d_gnt;
        o_mem_we    = w_d_gnt & i_d_we;
        o_mem_wdata = w_d_gnt ? i_d_wdata : {DATA_W{1'b0}};
        if (w_if_gnt) begin
            o_mem_addr = i_if_addr;
        end else if (w_d_gnt) begin
            o_mem_addr = i_d_addr;
        end else begin
            o_mem_addr = {ADDR_W{1'b0}};
        end
    end

    // Remember who issued a read so its data comes back to the right port next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= (w_if_gnt | w_d_gnt) & ~(w_d_gnt & i_d_we);
            r_rd_owner <= w_d_gnt;
        end
    end

    assign o_if_rvalid = r_rd_pend & ~r_rd_owner;
    assign o_d_rvalid  = r_rd_pend & r_rd_owner;
    assign o_if_rdata  = i_mem_rdata;
    assign o_d_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (STARVE_MAX 4 and 1) share directed stimulus; each has
// its own RAM and a per-cycle model of the arbitration rules, plus hand-computed literal checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int idx);
        return 32'hA5A5_0000 | (idx << 2);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SM = (g == 0) ? 4 : 1;

        logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
        logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
        logic [31:0] ram [1024];
        logic [31:0] mdl [1024];

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
            .clk(clk), .rst(rst),
            .i_if_req(if_req), .i_if_addr(if_addr),
            .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
            .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
            .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
            .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
            .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
        );

        initial begin
            for (int i = 0; i < 1024; i++) begin
                ram[i] = init_word(i);
                mdl[i] = init_word(i);
            end
        end

        // Single-port synchronous RAM, one cycle read latency.
        always @(posedge clk) begin
            if (mem_en) begin
                if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
                else        mem_rdata <= ram[mem_addr[11:2]];
            end
        end

        task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL dut%0d %s actual=%h expected=%h t=%0t", g, nm, act, exp, $time);
            end
        endtask

        // Model: 'run' counts contested data wins in a row; 'owed' means fetch must win the next contest.
        int          run = 0;
        bit          owed = 1'b0;
        bit          exp_if_rv = 1'b0;
        bit          exp_d_rv = 1'b0;
        logic [31:0] exp_rdata = 32'h0;

        always @(negedge clk) begin
            bit eg_if, eg_d;
            logic [31:0] ea, ew;
            if (rst) begin
                chk("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
                chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
                chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
                chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
                chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
                chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
                run = 0; owed = 1'b0; exp_if_rv = 1'b0; exp_d_rv = 1'b0;
            end else begin
                chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_if_rv});
                chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_d_rv});
                if (exp_if_rv) chk("if_rdata", if_rdata, exp_rdata);
                if (exp_d_rv)  chk("d_rdata", d_rdata, exp_rdata);
                if (if_req && d_req) begin
                    eg_if = owed;
                    eg_d  = !owed;
                end else begin
                    eg_if = if_req;
                    eg_d  = d_req;
                end
                ea = eg_if ? if_addr : (eg_d ? d_addr : 32'h0);
                ew = eg_d ? d_wdata : 32'h0;
                chk("if_gnt", {31'b0, if_gnt}, {31'b0, eg_if});
                chk("d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
                chk("mem_en", {31'b0, mem_en}, {31'b0, eg_if | eg_d});
                chk("mem_we", {31'b0, mem_we}, {31'b0, eg_d & d_we});
                chk("mem_addr", mem_addr, ea);
                chk("mem_wdata", mem_wdata, ew);
                exp_if_rv = eg_if;
                exp_d_rv  = eg_d && !d_we;
                exp_rdata = mdl[ea[11:2]];
                if (eg_d && d_we) mdl[d_addr[11:2]] = d_wdata;
                if (eg_if) begin
                    owed = 1'b0;
                    run  = 0;
                end else if (if_req && d_req) begin
                    run++;
                    if (run == SM) begin
                        owed = 1'b1;
                        run  = 0;
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic string gl(logic f, logic d);
        if (f) return "F";
        else if (d) return "D";
        else return "-";
    endfunction

    string s0, s1;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        cyc(); cyc();

        // Reset landing on an outstanding fetch read.
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        lit("pre_rst_if_gnt", {31'b0, g_dut[0].if_gnt}, 32'h1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        lit("rst_kills_if_rvalid", {31'b0, g_dut[0].if_rvalid}, 32'h0);
        lit("rst_forces_if_gnt0", {31'b0, g_dut[0].if_gnt}, 32'h0);
        lit("rst_forces_mem_en0", {31'b0, g_dut[0].mem_en}, 32'h0);
        cyc();
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        lit("post_rst_no_rvalid", {31'b0, g_dut[0].if_rvalid}, 32'h0);
        cyc();

        // Fetch-only stream.
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'h10 + 32'(i * 4);
            @(negedge clk);
            lit("fetch_gnt", {31'b0, g_dut[0].if_gnt}, 32'h1);
            if (i > 0) lit("fetch_rdata", g_dut[0].if_rdata, 32'hA5A5_000C + 32'(i * 4));
            cyc();
        end
        if_req = 1'b0;
        @(negedge clk);
        lit("fetch_rdata_last", g_dut[0].if_rdata, 32'hA5A5_0018);
        lit("fetch_rvalid_last", {31'b0, g_dut[0].if_rvalid}, 32'h1);
        cyc();

        // Sustained contest.
        s0 = ""; s1 = "";
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s0 = {s0, gl(g_dut[0].if_gnt, g_dut[0].d_gnt)};
            s1 = {s1, gl(g_dut[1].if_gnt, g_dut[1].d_gnt)};
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        checks++;
        if (s0 != "DDDDFD") begin
            failures++;
            $display("FAIL contest_seq_sm4 actual=%s expected=DDDDFD", s0);
        end
        checks++;
        if (s1 != "DFDFDF") begin
            failures++;
            $display("FAIL contest_seq_sm1 actual=%s expected=DFDFDF", s1);
        end
        cyc();

        // Store then load of the same word.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        lit("store_mem_we", {31'b0, g_dut[0].mem_we}, 32'h1);
        cyc();
        d_we = 1'b0; d_wdata = 32'h0;
        @(negedge clk);
        lit("no_rvalid_after_store", {31'b0, g_dut[0].d_rvalid}, 32'h0);
        cyc();
        d_req = 1'b0;
        @(negedge clk);
        lit("load_after_store_rvalid", {31'b0, g_dut[1].d_rvalid}, 32'h1);
        lit("load_after_store_rdata", g_dut[1].d_rdata, 32'hDEAD_BEEF);
        cyc();

        // Fetch grant followed by a data load: responses in order, not swapped.
        if_req = 1'b1; if_addr = 32'h20;
        cyc();
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h200;
        @(negedge clk);
        lit("ilv_if_rvalid", {31'b0, g_dut[0].if_rvalid}, 32'h1);
        lit("ilv_d_rvalid_early", {31'b0, g_dut[0].d_rvalid}, 32'h0);
        lit("ilv_if_rdata", g_dut[0].if_rdata, 32'hA5A5_0020);
        cyc();
        d_req = 1'b0;
        @(negedge clk);
        lit("ilv_d_rvalid", {31'b0, g_dut[0].d_rvalid}, 32'h1);
        lit("ilv_if_rvalid_late", {31'b0, g_dut[0].if_rvalid}, 32'h0);
        lit("ilv_d_rdata", g_dut[0].d_rdata, 32'hA5A5_0200);
        cyc();

        // Owed fetch survives an uncontested data grant.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
        repeat (4) cyc();
        if_req = 1'b0;
        cyc();
        if_req = 1'b1;
        @(negedge clk);
        lit("owed_fetch_sm4", {31'b0, g_dut[0].if_gnt}, 32'h1);
        lit("no_owed_sm1", {31'b0, g_dut[1].d_gnt}, 32'h1);
        cyc();
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
